// File: rtl/rv_ctl_mc2.sv
// ============================================================================
// Module   : rv_ctl_mc2
// Brief    : Multicycle RISC-V control FSM with memory handshake/fixed latency,
//            illegal-instruction/timeout trap and retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_ctl_mc2 #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MEM_LAT       = 1,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             memreq,
  output logic             memrw,
  output logic [1:0]       pcsource,
  output logic             pcwrite,
  output logic             pccen,
  output logic             irwrite,
  output logic [1:0]       wbsel,
  output logic             regwen,
  output logic [2:0]       immsel,
  output logic [1:0]       asel,
  output logic             bsel,
  output logic [3:0]       alusel,
  output logic             mdrwrite,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_LW_MEM    = 4'd3;
  localparam logic [3:0] S_LW_WB     = 4'd4;
  localparam logic [3:0] S_SW_MEM    = 4'd5;
  localparam logic [3:0] S_R_ALU     = 4'd6;
  localparam logic [3:0] S_I_ALU     = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BR_EXEC   = 4'd9;
  localparam logic [3:0] S_JAL_EXEC  = 4'd10;
  localparam logic [3:0] S_JALR_EXEC = 4'd11;
  localparam logic [3:0] S_LUI_WB    = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  // The wait counter only ever needs to reach the timeout (handshake) or the last latency cycle (fixed).
  localparam int c_WMAX   = MEM_HANDSHAKE ? TIMEOUT : MEM_LAT - 1;
  localparam int c_WCNT_W = $clog2(c_WMAX + 2);
  localparam logic [c_WCNT_W-1:0] c_WMAX_V   = c_WCNT_W'(c_WMAX);
  localparam logic [c_WCNT_W-1:0] c_LAT_LAST = c_WCNT_W'(MEM_LAT - 1);

  logic [3:0]          r_state;
  logic [3:0]          w_next;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]    r_instret;
  logic                w_mem_done;
  logic                w_timeout;
  logic                w_retire;

  wire [6:0] w_opcode = instr[6:0];
  wire [2:0] w_f3     = instr[14:12];
  wire       w_unused_bits = &{1'b0, instr[31], instr[29:15], instr[11:7], mem_ready};

  wire w_is_lw   = (w_opcode == 7'b0000011) && (w_f3 == 3'b010);
  wire w_is_sw   = (w_opcode == 7'b0100011) && (w_f3 == 3'b010);
  wire w_is_r    = (w_opcode == 7'b0110011);
  wire w_is_i    = (w_opcode == 7'b0010011);
  wire w_is_br   = (w_opcode == 7'b1100011) && (w_f3 != 3'b010) && (w_f3 != 3'b011);
  wire w_is_jal  = (w_opcode == 7'b1101111);
  wire w_is_jalr = (w_opcode == 7'b1100111) && (w_f3 == 3'b000);
  wire w_is_lui  = (w_opcode == 7'b0110111);

  generate
    if (MEM_HANDSHAKE) begin : g_handshake
      assign w_mem_done = mem_ready;
      assign w_timeout  = (r_wcnt == c_WMAX_V) && !mem_ready;
    end else begin : g_fixed
      assign w_mem_done = (r_wcnt == c_LAT_LAST);
      assign w_timeout  = 1'b0;
    end
  endgenerate

  logic w_br_taken;
  always_comb begin
    w_br_taken = 1'b0;
    case (w_f3)
      3'b000:  w_br_taken = zero;
      3'b001:  w_br_taken = !zero;
      3'b100:  w_br_taken = lt;
      3'b101:  w_br_taken = !lt;
      3'b110:  w_br_taken = ltu;
      3'b111:  w_br_taken = !ltu;
      default: w_br_taken = 1'b0;
    endcase
  end

  // Only retiring states transition back into FETCH.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);
  assign instret  = r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wcnt    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wcnt <= '0;
      else if (r_wcnt != c_WMAX_V)
        r_wcnt <= r_wcnt + c_WCNT_W'(1);
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_mem_done)     w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        if (w_is_lw || w_is_sw) w_next = S_MEM_ADDR;
        else if (w_is_r)        w_next = S_R_ALU;
        else if (w_is_i)        w_next = S_I_ALU;
        else if (w_is_br)       w_next = S_BR_EXEC;
        else if (w_is_jal)      w_next = S_JAL_EXEC;
        else if (w_is_jalr)     w_next = S_JALR_EXEC;
        else if (w_is_lui)      w_next = S_LUI_WB;
        else                    w_next = S_TRAP;
      end
      S_MEM_ADDR: w_next = w_is_lw ? S_LW_MEM : S_SW_MEM;
      S_LW_MEM: begin
        if (w_mem_done)     w_next = S_LW_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_SW_MEM: begin
        if (w_mem_done)     w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_R_ALU, S_I_ALU: w_next = S_ALU_WB;
      S_LW_WB, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC, S_JALR_EXEC, S_LUI_WB: w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced to their idle defaults while rst is held.
  always_comb begin
    memreq   = 1'b0;
    memrw    = 1'b0;
    pcsource = 2'd0;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    wbsel    = 2'd0;
    regwen   = 1'b0;
    immsel   = 3'd2;
    asel     = 2'd0;
    bsel     = 1'b0;
    alusel   = 4'b0000;
    mdrwrite = 1'b0;
    trap     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          memreq = 1'b1;
          pccen  = 1'b1;
          if (w_mem_done) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
          end
        end
        S_DECODE: begin
          immsel = 3'd2;
          asel   = 2'd1;
          bsel   = 1'b1;
        end
        S_MEM_ADDR: begin
          immsel = w_is_lw ? 3'd0 : 3'd1;
          bsel   = 1'b1;
        end
        S_LW_MEM: begin
          memreq   = 1'b1;
          mdrwrite = w_mem_done;
        end
        S_LW_WB: begin
          wbsel  = 2'd2;
          regwen = 1'b1;
        end
        S_SW_MEM: begin
          memreq = 1'b1;
          memrw  = 1'b1;
        end
        S_R_ALU: alusel = {w_f3, instr[30]};
        S_I_ALU: begin
          immsel = 3'd0;
          bsel   = 1'b1;
          alusel = {w_f3, (w_f3 == 3'b101) & instr[30]};
        end
        S_ALU_WB: begin
          wbsel  = 2'd1;
          regwen = 1'b1;
        end
        S_BR_EXEC: begin
          alusel   = 4'b0001;
          pcsource = 2'd1;
          pcwrite  = w_br_taken;
        end
        S_JAL_EXEC: begin
          immsel   = 3'd3;
          asel     = 2'd1;
          bsel     = 1'b1;
          pcsource = 2'd2;
          pcwrite  = 1'b1;
          regwen   = 1'b1;
        end
        S_JALR_EXEC: begin
          immsel   = 3'd0;
          bsel     = 1'b1;
          pcsource = 2'd2;
          pcwrite  = 1'b1;
          regwen   = 1'b1;
        end
        S_LUI_WB: begin
          immsel = 3'd4;
          wbsel  = 2'd3;
          regwen = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
